// File: rtl/seg7_scan_driver.sv
// Multiplexed NUM_DIGITS seven-segment scan driver with shadow register, hex glyphs and leading-zero blanking.
// Optional per-digit blinking is built when SEG7_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned BLINK_DIV   = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_tick;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [IW-1:0]           w_idx_next;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [NUM_DIGITS-1:0]   w_blink_hide;
    logic                    w_zero_run;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic [6:0]              w_seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = hex ? 7'b1110111 : 7'b0000000;
            4'hB: g = hex ? 7'b0011111 : 7'b0000000;
            4'hC: g = hex ? 7'b1001110 : 7'b0000000;
            4'hD: g = hex ? 7'b0111101 : 7'b0000000;
            4'hE: g = hex ? 7'b1001111 : 7'b0000000;
            default: g = hex ? 7'b1000111 : 7'b0000000;
        endcase
        return g;
    endfunction

    always_comb begin
        w_slot_end = (r_presc == PRESC_LAST);
        w_wrap     = w_slot_end && (r_idx == IDX_LAST);
        w_idx_next = r_idx;
        if (w_slot_end) begin
            w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Scan from the most significant digit down; a digit blanks while everything above and including it is zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_mask  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_zero_run = w_zero_run & (r_shadow[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
            if ((NUM_DIGITS - 1 - i) != 0) begin
                w_lz_mask[NUM_DIGITS-1-i] = lz_blank & w_zero_run;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic          w_blink_roll;
    logic          w_phase_next;

    always_comb begin
        w_blink_roll = w_wrap && (r_blink_cnt == BLINK_LAST);
        w_phase_next = r_phase ^ w_blink_roll;
        w_blink_hide = blink_mask & {NUM_DIGITS{w_phase_next}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_blink_cnt <= w_blink_roll ? '0 : r_blink_cnt + 1'b1;
            end
            r_phase <= w_phase_next;
        end
    end
`else
    logic w_unused_blink;
    assign w_unused_blink = ^{blink_mask, BLINK_DIV[0]};
    assign w_blink_hide   = '0;
`endif

    always_comb begin
        w_nib     = '0;
        w_blank   = 1'b0;
        w_an_next = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_an_next[i] = (w_idx_next == IW'(i));
            if (w_idx_next == IW'(i)) begin
                w_nib   = r_shadow[i*4 +: 4];
                w_blank = w_lz_mask[i] | w_blink_hide[i];
            end
        end
        w_seg_next = w_blank ? 7'b0000000 : glyph(w_nib, hex_mode);
    end

    // Outputs are computed from the pre-edge shadow, giving the one-cycle load latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_seg    <= '0;
            r_an     <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
            r_idx   <= w_idx_next;
            if (load) begin
                r_shadow <= value;
            end
            r_seg  <= w_seg_next;
            r_an   <= w_an_next;
            r_tick <= w_wrap;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_tick;

endmodule
